// File: rtl/axi_hdr_pkg.sv
// rtl/axi_hdr_pkg.sv - shared state type and keep helpers for the insert-header sequencer
package axi_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Wide enough for any supported beat; users slice down to their byte count.
    localparam int KEEP_MAX_WD = 64;
    localparam logic [KEEP_MAX_WD-1:0] KEEP_ALL_ONES = '1;
    localparam logic [KEEP_MAX_WD-1:0] KEEP_ZERO     = '0;

    function automatic int unsigned keep_popcount(input logic [KEEP_MAX_WD-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < KEEP_MAX_WD; i++) begin
            cnt = cnt + {31'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/insert_header_sequencer_data_combiner.sv
// rtl/insert_header_sequencer_data_combiner.sv - merges low-aligned residue bytes ahead of MSB-aligned payload bytes
module data_combiner
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      data_1_i,
    input  logic [DATA_BYTE_WD-1:0] keep_1_i,
    input  logic [DATA_WD-1:0]      data_2_i,
    input  logic [DATA_BYTE_WD-1:0] keep_2_i,
    output logic [DATA_WD-1:0]      combined_data_1_o,
    output logic [DATA_BYTE_WD-1:0] combined_keep_1_o,
    output logic [DATA_WD-1:0]      combined_data_2_o,
    output logic [DATA_BYTE_WD-1:0] combined_keep_2_o,
    output logic                    combine_overflow_o
);

    localparam int NB = DATA_BYTE_WD;
    localparam logic [BYTE_CNT_WD+1:0] NB_CNT = (BYTE_CNT_WD + 2)'(NB);

    logic [BYTE_CNT_WD:0]    cnt_1;
    logic [BYTE_CNT_WD:0]    cnt_2;
    logic [BYTE_CNT_WD+1:0]  cnt_sum;
    logic [BYTE_CNT_WD+1:0]  cnt_spill;
    logic [DATA_WD-1:0]      data_1_m;
    logic [DATA_WD-1:0]      data_2_m;
    logic [DATA_WD-1:0]      data_1_msb;
    logic [2*DATA_WD-1:0]    merged;
    logic [DATA_BYTE_WD-1:0] ones;

    always_comb begin
        cnt_1    = (BYTE_CNT_WD + 1)'(keep_popcount(KEEP_MAX_WD'(keep_1_i)));
        cnt_2    = (BYTE_CNT_WD + 1)'(keep_popcount(KEEP_MAX_WD'(keep_2_i)));
        data_1_m = '0;
        data_2_m = '0;
        for (int b = 0; b < NB; b++) begin
            data_1_m[b*8 +: 8] = keep_1_i[b] ? data_1_i[b*8 +: 8] : 8'h00;
            data_2_m[b*8 +: 8] = keep_2_i[b] ? data_2_i[b*8 +: 8] : 8'h00;
        end
        // Residue goes first in stream order, so lift it to the top before appending payload.
        data_1_msb = data_1_m << (8 * (NB - int'(cnt_1)));
        merged     = {data_1_msb, {DATA_WD{1'b0}}}
                   | ({data_2_m, {DATA_WD{1'b0}}} >> (8 * int'(cnt_1)));
        cnt_sum            = (BYTE_CNT_WD + 2)'(cnt_1) + (BYTE_CNT_WD + 2)'(cnt_2);
        combine_overflow_o = cnt_sum > NB_CNT;
        cnt_spill          = combine_overflow_o ? cnt_sum - NB_CNT : '0;
        ones               = '1;
        combined_data_1_o  = merged[2*DATA_WD-1 -: DATA_WD];
        combined_keep_1_o  = ~(ones >> cnt_sum);
        // Spilled bytes are handed back low-aligned, the same shape as a header residue.
        combined_data_2_o  = merged[DATA_WD-1:0] >> (8 * (NB - int'(cnt_spill)));
        combined_keep_2_o  = ~(ones << cnt_spill);
    end

endmodule

// File: rtl/insert_header_sequencer.sv
// rtl/insert_header_sequencer.sv - prepends one variable-length header per frame onto an AXI-stream payload
module insert_header_sequencer
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    busy
);

    localparam logic [DATA_BYTE_WD-1:0] KEEP_ONES = KEEP_ALL_ONES[DATA_BYTE_WD-1:0];
    localparam logic [DATA_BYTE_WD-1:0] KEEP_NONE = KEEP_ZERO[DATA_BYTE_WD-1:0];

    state_e                  state_q;
    logic [DATA_WD-1:0]      res_data_q;
    logic [DATA_BYTE_WD-1:0] res_keep_q;
    logic                    valid_out_q;
    logic [DATA_WD-1:0]      data_out_q;
    logic [DATA_BYTE_WD-1:0] keep_out_q;
    logic                    last_out_q;

    logic                    slot_free;
    logic                    hdr_fire;
    logic                    pay_fire;
    logic [DATA_WD-1:0]      comb_in_data_2;
    logic [DATA_BYTE_WD-1:0] comb_in_keep_2;
    logic [DATA_WD-1:0]      comb_data_1;
    logic [DATA_BYTE_WD-1:0] comb_keep_1;
    logic [DATA_WD-1:0]      comb_data_2;
    logic [DATA_BYTE_WD-1:0] comb_keep_2;
    logic                    comb_ovf;

    assign slot_free    = !valid_out_q || ready_out;
    // Header acceptance ignores the output slot so a stalled last beat does not block the next frame.
    assign ready_insert = rst_n && (state_q == ST_IDLE);
    assign ready_in     = (state_q == ST_STREAM) && slot_free;
    assign hdr_fire     = valid_insert && ready_insert;
    assign pay_fire     = valid_in && ready_in;
    assign busy         = (state_q != ST_IDLE);

    // Outside STREAM the second operand is empty, which simply left-aligns the residue.
    assign comb_in_data_2 = (state_q == ST_STREAM) ? data_in : '0;
    assign comb_in_keep_2 = (state_q == ST_STREAM) ? keep_in : KEEP_NONE;

    data_combiner #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_combiner (
        .data_1_i           (res_data_q),
        .keep_1_i           (res_keep_q),
        .data_2_i           (comb_in_data_2),
        .keep_2_i           (comb_in_keep_2),
        .combined_data_1_o  (comb_data_1),
        .combined_keep_1_o  (comb_keep_1),
        .combined_data_2_o  (comb_data_2),
        .combined_keep_2_o  (comb_keep_2),
        .combine_overflow_o (comb_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_data_q  <= '0;
            res_keep_q  <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (slot_free) begin
                        valid_out_q <= 1'b0;
                    end
                    if (hdr_fire) begin
                        res_data_q <= data_insert;
                        res_keep_q <= keep_insert;
                        state_q    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pay_fire) begin
                        valid_out_q <= 1'b1;
                        data_out_q  <= comb_data_1;
                        keep_out_q  <= comb_keep_1;
                        res_data_q  <= comb_data_2;
                        res_keep_q  <= comb_keep_2;
                        if (last_in) begin
                            last_out_q <= !comb_ovf;
                            state_q    <= comb_ovf ? ST_FLUSH : ST_IDLE;
                        end else begin
                            last_out_q <= 1'b0;
                        end
                    end else if (slot_free) begin
                        valid_out_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (slot_free) begin
                        valid_out_q <= 1'b1;
                        data_out_q  <= comb_data_1;
                        keep_out_q  <= comb_keep_1;
                        last_out_q  <= 1'b1;
                        res_data_q  <= '0;
                        res_keep_q  <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && valid_out_q && !last_out_q) begin
            assert (int'(keep_popcount(KEEP_MAX_WD'(keep_out_q))) == DATA_BYTE_WD && keep_out_q == KEEP_ONES);
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;

endmodule

// File: tb/tb_insert_header_sequencer.sv
// tb/tb_insert_header_sequencer.sv - randomized byte-queue scoreboard bench for insert_header_sequencer
module tb_insert_header_sequencer;

    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
    } hdr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_insert;
    logic [DW-1:0] data_insert;
    logic [NB-1:0] keep_insert;
    logic          ready_insert;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [NB-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [NB-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          busy;

    always #5 clk = ~clk;

    insert_header_sequencer #(.DATA_WD(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .ready_insert (ready_insert),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .busy         (busy)
    );

    hdr_t  hdr_q[$];
    beat_t pay_q[$];
    beat_t exp_q[$];

    int checks = 0;
    int failures = 0;
    bit drv_en = 1'b0;
    bit hold_hdr = 1'b0;
    int p_valid = 100;
    int p_ready = 100;
    bit hdr_acc = 1'b0;
    bit pay_acc = 1'b0;
    int frames_open = 0;
    int pay_cnt = 0;
    bit prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    // Reference: the output stream is the header bytes then payload bytes, repacked MSB-first into full beats.
    task automatic add_frame(input hdr_t h, input beat_t beats[$]);
        logic [7:0] bq[$];
        beat_t o;
        int nh, k, n;
        nh = $countones(h.keep);
        for (int i = nh - 1; i >= 0; i--) bq.push_back(h.data[i*8 +: 8]);
        foreach (beats[bi]) begin
            k = $countones(beats[bi].keep);
            for (int j = NB - 1; j >= NB - k; j--) bq.push_back(beats[bi].data[j*8 +: 8]);
            pay_q.push_back(beats[bi]);
        end
        hdr_q.push_back(h);
        while (bq.size() > 0) begin
            o = '0;
            n = (bq.size() >= NB) ? NB : bq.size();
            for (int j = 0; j < n; j++) begin
                o.data[(NB-1-j)*8 +: 8] = bq.pop_front();
                o.keep[NB-1-j] = 1'b1;
            end
            o.last = (bq.size() == 0);
            exp_q.push_back(o);
        end
    endtask

    task automatic rand_frame();
        hdr_t h;
        beat_t x;
        beat_t bs[$];
        int nh, nb, kl;
        h = '0;
        nh = $urandom_range(0, NB);
        for (int i = 0; i < nh; i++) begin
            h.keep[i] = 1'b1;
            h.data[i*8 +: 8] = 8'($urandom);
        end
        nb = $urandom_range(1, 5);
        for (int b = 0; b < nb; b++) begin
            x = '0;
            kl = (b == nb - 1) ? int'($urandom_range(1, NB)) : NB;
            for (int j = NB - 1; j >= NB - kl; j--) begin
                x.keep[j] = 1'b1;
                x.data[j*8 +: 8] = 8'($urandom);
            end
            x.last = (b == nb - 1);
            bs.push_back(x);
        end
        add_frame(h, bs);
    endtask

    task automatic run_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || hdr_q.size() > 0 || pay_q.size() > 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("FAIL drain_timeout actual_cycles=%0d required_below=%0d outstanding=%0d", n, max_cyc, exp_q.size());
        end
        repeat (2) @(negedge clk);
        check("idle_after_frame", busy, 1'b0);
    endtask

    // Stimulus driver: inputs change 1 time unit after the rising edge.
    initial begin
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!drv_en) begin
                valid_insert = 1'b0;
                valid_in = 1'b0;
                ready_out = 1'b0;
            end else begin
                if (hdr_acc && hdr_q.size() > 0) hdr_q.delete(0);
                if (pay_acc && pay_q.size() > 0) pay_q.delete(0);
                if (!valid_insert || hdr_acc)
                    valid_insert = !hold_hdr && hdr_q.size() > 0 && (int'($urandom_range(1, 100)) <= p_valid);
                if (hdr_q.size() > 0) begin
                    data_insert = hdr_q[0].data;
                    keep_insert = hdr_q[0].keep;
                end
                if (!valid_in || pay_acc)
                    valid_in = pay_q.size() > 0 && (int'($urandom_range(1, 100)) <= p_valid);
                if (pay_q.size() > 0) begin
                    data_in = pay_q[0].data;
                    keep_in = pay_q[0].keep;
                    last_in = pay_q[0].last;
                end
                ready_out = int'($urandom_range(1, 100)) <= p_ready;
            end
        end
    end

    // Monitor: samples on the falling edge, scores every output handshake and protocol rule.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hdr_acc = 1'b0;
                pay_acc = 1'b0;
                frames_open = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", valid_out, 1'b1);
                    check("hold_beat", {data_out, keep_out, last_out}, prev_beat);
                end
                if (valid_out && !ready_out) check("stall_ready_in", ready_in, 1'b0);
                check("busy_vs_ready_insert", busy, !ready_insert);
                if (ready_insert) check("hdr_gate_frames_open", frames_open, 0);
                if (ready_in) check("pay_gate_frame_open", frames_open > 0, 1'b1);
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h/%0h/%0b required=none", data_out, keep_out, last_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", data_out, e.data);
                        check("out_keep", keep_out, e.keep);
                        check("out_last", last_out, e.last);
                    end
                end
                prev_stall = valid_out && !ready_out;
                prev_beat = mk(data_out, keep_out, last_out);
                hdr_acc = valid_insert && ready_insert;
                pay_acc = valid_in && ready_in;
                if (hdr_acc) frames_open++;
                if (pay_acc) begin
                    pay_cnt++;
                    if (last_in) frames_open--;
                end
            end
        end
    end

    initial begin
        hdr_t h;
        beat_t bs[$];
        int start, n;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, 0);
        check("rst_keep_out", keep_out, 0);
        check("rst_last_out", last_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready_insert", ready_insert, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_insert", ready_insert, 1'b1);
        check("post_rst_ready_in", ready_in, 1'b0);
        drv_en = 1'b1;

        // Basic overflow-free frame
        p_valid = 80; p_ready = 70;
        h.data = 32'h0000AABB; h.keep = 4'b0011;
        bs.delete();
        bs.push_back(mk(32'h11223344, 4'b1111, 1'b0));
        bs.push_back(mk(32'h55667788, 4'b1111, 1'b0));
        bs.push_back(mk(32'h99AA0000, 4'b1100, 1'b1));
        add_frame(h, bs);
        check("pin_basic_0", exp_q[0], mk(32'hAABB1122, 4'b1111, 1'b0));
        check("pin_basic_1", exp_q[1], mk(32'h33445566, 4'b1111, 1'b0));
        check("pin_basic_2", exp_q[2], mk(32'h778899AA, 4'b1111, 1'b1));
        run_drain(500);

        // Final merge overflows into a flush beat
        bs.delete();
        bs.push_back(mk(32'h11223344, 4'b1111, 1'b0));
        bs.push_back(mk(32'h99AABBCC, 4'b1110, 1'b1));
        add_frame(h, bs);
        check("pin_flush_0", exp_q[0], mk(32'hAABB1122, 4'b1111, 1'b0));
        check("pin_flush_1", exp_q[1], mk(32'h334499AA, 4'b1111, 1'b0));
        check("pin_flush_2", exp_q[2], mk(32'hBB000000, 4'b1000, 1'b1));
        run_drain(500);

        // Empty header passes payload straight through
        h.data = 32'h0; h.keep = 4'b0000;
        bs.delete();
        bs.push_back(mk(32'h01020304, 4'b1111, 1'b0));
        bs.push_back(mk(32'h05060000, 4'b1100, 1'b1));
        add_frame(h, bs);
        check("pin_keep0_0", exp_q[0], mk(32'h01020304, 4'b1111, 1'b0));
        check("pin_keep0_1", exp_q[1], mk(32'h05060000, 4'b1100, 1'b1));
        run_drain(500);

        // Full-width header forces a flush on a single-beat frame
        h.data = 32'hDEADBEEF; h.keep = 4'b1111;
        bs.delete();
        bs.push_back(mk(32'h01020304, 4'b1111, 1'b1));
        add_frame(h, bs);
        check("pin_full_0", exp_q[0], mk(32'hDEADBEEF, 4'b1111, 1'b0));
        check("pin_full_1", exp_q[1], mk(32'h01020304, 4'b1111, 1'b1));
        run_drain(500);

        // Three-cycle downstream stall mid-frame
        p_valid = 100; p_ready = 100;
        h.data = 32'h00000077; h.keep = 4'b0001;
        bs.delete();
        bs.push_back(mk(32'hA1A2A3A4, 4'b1111, 1'b0));
        bs.push_back(mk(32'hB1B2B3B4, 4'b1111, 1'b0));
        bs.push_back(mk(32'hC1C2C3C4, 4'b1111, 1'b0));
        bs.push_back(mk(32'hD1D20000, 4'b1100, 1'b1));
        add_frame(h, bs);
        n = 0;
        while (!valid_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_setup_timeout", n < 50, 1'b1);
        p_ready = 0;
        repeat (3) @(posedge clk);
        p_ready = 100;
        run_drain(500);

        // Payload offered before its header, then two headers back to back
        hold_hdr = 1'b1;
        rand_frame();
        rand_frame();
        start = pay_cnt;
        repeat (6) @(negedge clk);
        check("early_payload_ready_in", ready_in, 1'b0);
        check("early_payload_accepted", pay_cnt - start, 0);
        hold_hdr = 1'b0;
        run_drain(500);

        // Randomized frames with random bubbles and backpressure
        p_valid = 70; p_ready = 60;
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 30; f++) rand_frame();
            run_drain(5000);
        end

        // Reset in the middle of a frame
        p_valid = 100; p_ready = 100;
        h.data = 32'h00CCDDEE; h.keep = 4'b0111;
        bs.delete();
        for (int b = 0; b < 6; b++) bs.push_back(mk(32'h10203040 + b, 4'b1111, b == 5));
        add_frame(h, bs);
        start = pay_cnt;
        n = 0;
        while (pay_cnt < start + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midframe_setup_timeout", n < 100, 1'b1);
        #2;
        rst_n = 1'b0;
        drv_en = 1'b0;
        #1;
        check("async_rst_valid_out", valid_out, 1'b0);
        check("async_rst_last_out", last_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        hdr_q.delete();
        pay_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drv_en = 1'b1;
        h.data = 32'h0000AABB; h.keep = 4'b0011;
        bs.delete();
        bs.push_back(mk(32'h11223344, 4'b1111, 1'b0));
        bs.push_back(mk(32'h99AABBCC, 4'b1110, 1'b1));
        add_frame(h, bs);
        run_drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/insert_header_sequencer.md
Name: insert_header_sequencer

Overview:
Frame-level controller that sequences the data_combiner datapath to prepend a variable-length header onto an AXI-stream frame. It accepts one header per frame, carries a residue of unaligned bytes from beat to beat, and emits a re-aligned output stream. When the final merge overflows, it issues one extra flush beat. It sits between the upstream source and the downstream sink inside the insert-header top level.

Parameters:
DATA_WD, 32, stream data width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width; counts use BYTE_CNT_WD+1 bits

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
valid_insert  in  1  header valid
data_insert  in  DATA_WD  header bytes, valid bytes low-aligned
keep_insert  in  DATA_BYTE_WD  header keep, contiguous from bit 0 (e.g. 4'b0011); all-zero allowed
ready_insert  out  1  header accepted when valid_insert && ready_insert
valid_in  in  1  payload valid
data_in  in  DATA_WD  payload, valid bytes MSB-aligned
keep_in  in  DATA_BYTE_WD  payload keep: all-ones except on the last beat, which is contiguous from MSB and non-zero
last_in  in  1  last payload beat
ready_in  out  1  payload ready
valid_out  out  1  output valid
data_out  out  DATA_WD  merged data, MSB-aligned
keep_out  out  DATA_BYTE_WD  output keep, contiguous from MSB
last_out  out  1  last output beat
ready_out  in  1  downstream ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; residue data/keep=0; valid_out=0, data_out=0, keep_out=0, last_out=0; ready_insert=0 during reset; busy=0.
- Output register slot is "free" when !valid_out || ready_out. valid_out/data_out/keep_out/last_out hold stable while valid_out && !ready_out.
- States:
  - IDLE: ready_insert=1, ready_in=0. On header handshake, load the residue (data_insert, keep_insert) and go to STREAM. No output beat is produced.
  - STREAM: ready_insert=0, ready_in=free.
  - FLUSH: ready_insert=0, ready_in=0.
- STREAM combiner inputs: data_1/keep_1 = residue, data_2/keep_2 = data_in/keep_in.
- On a payload handshake in STREAM, the output register loads combined_data_1/combined_keep_1 on the next edge, so latency is 1 cycle.
  - Residue loads combined_data_2/combined_keep_2. When there is no overflow, the residue becomes 0.
  - !last_in: last_out=0, stay in STREAM.
  - last_in && !combine_overflow: last_out=1, go to IDLE.
  - last_in && combine_overflow: last_out=0, go to FLUSH.
- FLUSH combiner inputs: data_1/keep_1 = residue, data_2=0, keep_2=0. This left-aligns the residue.
  - When the slot is free, load the output with the combined result and last_out=1, clear the residue, go to IDLE.
- Output slot free with no load: valid_out drops to 0 on the next edge.
- A non-last beat always fills all bytes: keep_out=all-ones whenever last_out=0.
- keep_insert=0: pure pass-through, output equals input beat-for-beat.
- keep_insert=all-ones: every beat overflows; the frame takes one extra flush beat.
- ready_insert in IDLE depends only on state, not on ready_out. A header may be accepted while the previous frame's last beat is still stalled at the output.
- Headers offered in STREAM/FLUSH and payload offered in IDLE/FLUSH are held off and never dropped.
- Reset asserted mid-frame: all state cleared immediately. The partial frame is discarded with no last_out emitted.

Decomposition:
- Shared package axi_hdr_pkg holds:
  - state enum (IDLE, STREAM, FLUSH);
  - localparam helpers for all-ones and zero keep;
  - a keep popcount function for assertions.
- Sub-module: the existing data_combiner, instantiated once, with its inputs muxed by state. The output register and residue register live in this block.

Test Plan (DATA_WD=32):
- Basic overflow-free frame.
  - Stimulus: header 0x0000AABB/0011; beats 0x11223344/1111, 0x55667788/1111, 0x99AA0000/1100 last.
  - Required output: 0xAABB1122/1111, 0x33445566/1111, 0x778899AA/1111 last; then state returns to IDLE.
- Flush case.
  - Stimulus: same header; beats 0x11223344/1111, 0x99AABBCC/1110 last.
  - Required output: 0xAABB1122/1111, 0x3344 99AA/1111, then FLUSH 0xBB000000/1000 last.
- Backpressure.
  - Stimulus: hold ready_out=0 for 3 cycles mid-frame.
  - Required response: data_out/keep_out stable, ready_in=0; no byte lost or duplicated after release.
- Header width extremes.
  - keep_insert=0000 with beats 0x01020304/1111, 0x05060000/1100 last: output is identical to input.
  - keep_insert=1111 (0xDEADBEEF) with one beat 0x01020304/1111 last: output 0xDEADBEEF/1111, then 0x01020304/1111 last.
- Ordering.
  - Stimulus: valid_in asserted before any header; two headers back-to-back.
  - Required response: ready_in=0 until the header is accepted; the second header waits until IDLE.
- Reset mid-frame.
  - Stimulus: assert rst_n=0 during STREAM.
  - Required response: valid_out=0 asynchronously; the next frame after release is correct with no stale residue.
